// File: rtl/spdif_tx_if.sv
// PCM sample-pair handshake into the S/PDIF transmitter.
// A pair transfers on a rising clk where in_valid && in_ready. The master holds in_valid and data stable until then, and ready may be high before valid.
interface spdif_tx_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_left;
  logic [23:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/spdif_tx_encoder.sv
// IEC 60958 (S/PDIF) biphase-mark transmitter: 24-bit stereo pairs in, one BMC line out.
// Optional: define SPDIF_TX_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_cnt output.
module spdif_tx_encoder #(
  parameter int CLK_DIV          = 4,
  parameter int FRAMES_PER_BLOCK = 192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  spdif_tx_if.slave   pcm,
  input  logic [31:0] cs_word,
  output logic        spdif_tx,
  output logic        block_start,
  output logic        underrun,
`ifdef SPDIF_TX_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = (FRAMES_PER_BLOCK > 2) ? $clog2(FRAMES_PER_BLOCK) : 1;
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, BODY = 2'd2} state_t;
  state_t state_q, state_d;

  logic [PW-1:0] presc_q;
  logic [5:0]    hc_q;
  logic          sub_q;
  logic [FW-1:0] frame_q;
  logic          buf_full_q;
  logic [23:0]   buf_l_q, buf_r_q, aud_l_q, aud_r_q;
  logic          v_q, inv_q, tx_q;
  logic [31:0]   cs_q;

  logic presc_last, frame_start, load_now, accept;
  logic [4:0]  slot;
  logic [31:0] aud_ext;
  logic [7:0]  base;
  logic        c_bit, slot_bit, pre_bit, next_tx;

  assign presc_last = (presc_q == PW'(CLK_DIV - 1));
  assign accept     = pcm.in_valid && pcm.in_ready;
  assign spdif_tx   = tx_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRE;
      PRE:     if (hc_q == 6'd7 && presc_last) state_d = BODY;
      BODY:    if (hc_q == 6'd63 && presc_last) state_d = PRE;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Frame start is the first clock of the left preamble; gated by enable so an abort wins.
  always_comb begin
    frame_start  = enable && (state_q == PRE) && (hc_q == 6'd0) && (presc_q == '0) && !sub_q;
    load_now     = frame_start && buf_full_q;
    underrun     = frame_start && !buf_full_q;
    block_start  = frame_start && (frame_q == '0);
    pcm.in_ready = rst_n && enable && (!buf_full_q || load_now);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || state_q == IDLE) begin
      presc_q <= '0;
      hc_q    <= '0;
      sub_q   <= 1'b0;
      frame_q <= '0;
    end else if (presc_last) begin
      presc_q <= '0;
      hc_q    <= hc_q + 6'd1;
      if (hc_q == 6'd63) begin
        sub_q <= ~sub_q;
        if (sub_q) frame_q <= (frame_q == FW'(FRAMES_PER_BLOCK - 1)) ? '0 : frame_q + 1'b1;
      end
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
    end else if (accept) begin
      buf_full_q <= 1'b1;
      buf_l_q    <= pcm.in_left;
      buf_r_q    <= pcm.in_right;
    end else if (load_now) begin
      buf_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aud_l_q <= '0;
      aud_r_q <= '0;
      v_q     <= 1'b0;
      cs_q    <= '0;
    end else if (frame_start) begin
      aud_l_q <= buf_full_q ? buf_l_q : 24'd0;
      aud_r_q <= buf_full_q ? buf_r_q : 24'd0;
      v_q     <= !buf_full_q;
      if (frame_q == '0) cs_q <= cs_word;
    end
  end

  // Slot bits and preamble levels for the half-cell about to be driven.
  always_comb begin
    slot     = hc_q[5:1];
    aud_ext  = {8'd0, (sub_q ? aud_r_q : aud_l_q)};
    c_bit    = ((frame_q >> 5) == '0) ? cs_q[frame_q[4:0]] : 1'b0;
    slot_bit = 1'b0;
    if (slot >= 5'd4 && slot <= 5'd27) slot_bit = aud_ext[slot - 5'd4];
    else if (slot == 5'd28)            slot_bit = v_q;
    else if (slot == 5'd30)            slot_bit = c_bit;
    else if (slot == 5'd31)            slot_bit = (^aud_ext) ^ v_q ^ c_bit;
    base     = sub_q ? PRE_W : ((frame_q == '0) ? PRE_B : PRE_M);
    pre_bit  = base[3'd7 - hc_q[2:0]] ^ ((hc_q == 6'd0) ? tx_q : inv_q);
    if (state_q == PRE) next_tx = pre_bit;
    else if (!hc_q[0])  next_tx = ~tx_q;
    else                next_tx = tx_q ^ slot_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || state_q == IDLE) begin
      tx_q  <= 1'b0;
      inv_q <= 1'b0;
    end else if (presc_q == '0) begin
      tx_q <= next_tx;
      if (state_q == PRE && hc_q == 6'd0) inv_q <= tx_q;
    end
  end

`ifdef SPDIF_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || !enable)                       underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule
